// File: rtl/activ4_stim.sv
// Serial MSB-first stimulus generator for the Activity 4 detector; x_valid is its clock enable.
// Button-to-x_valid latency DEBOUNCE_CYCLES+3 cycles; no backpressure, load always preempts advance.
module activ4_stim #(
    parameter int PAT_W           = 8,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int AUTO_DIV        = 50_000_000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     btn_load,
    input  logic                     btn_step,
    input  logic                     auto_run,
    input  logic [PAT_W-1:0]         pattern,
    output logic                     x,
    output logic                     x_valid,
    output logic [$clog2(PAT_W)-1:0] bit_idx,
    output logic                     busy,
    output logic                     done
);

    localparam int IW = $clog2(PAT_W);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AW = $clog2(AUTO_DIV + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW-1:0] DIV_LAST = AW'(AUTO_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(PAT_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_EMIT, S_DONE} state_t;

    logic [1:0]       r_load_sync;
    logic [1:0]       r_step_sync;
    logic [1:0]       r_auto_sync;
    logic [DW-1:0]    r_deb_cnt [2];
    logic [1:0]       r_deb;
    logic [1:0]       r_deb_d;
    logic [AW-1:0]    r_div;
    state_t           r_state;
    logic [PAT_W-1:0] r_shreg;
    logic [IW-1:0]    r_idx;
    logic             r_x;
    logic             r_x_valid;
    logic             r_busy;
    logic             r_done;

    logic [1:0] w_sync;
    logic       w_load_ev;
    logic       w_step_ev;
    logic       w_auto;
    logic       w_tick;
    logic       w_adv;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_load_sync <= '0;
            r_step_sync <= '0;
            r_auto_sync <= '0;
        end else begin
            r_load_sync <= {r_load_sync[0], btn_load};
            r_step_sync <= {r_step_sync[0], btn_step};
            r_auto_sync <= {r_auto_sync[0], auto_run};
        end
    end

    assign w_sync = {r_step_sync[1], r_load_sync[1]};
    assign w_auto = r_auto_sync[1];

    // Index 0 debounces load, index 1 debounces step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_deb        <= '0;
            r_deb_d      <= '0;
            r_deb_cnt[0] <= '0;
            r_deb_cnt[1] <= '0;
        end else begin
            r_deb_d <= r_deb;
            for (int i = 0; i < 2; i++) begin
                if (w_sync[i] != r_deb[i]) begin
                    if (r_deb_cnt[i] == DEB_LAST) begin
                        r_deb[i]     <= w_sync[i];
                        r_deb_cnt[i] <= '0;
                    end else begin
                        r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
                    end
                end else begin
                    r_deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_load_ev = r_deb[0] & ~r_deb_d[0];
    assign w_step_ev = r_deb[1] & ~r_deb_d[1];

    assign w_tick = (r_state == S_SHIFT) && w_auto && (r_div == DIV_LAST);
    assign w_adv  = w_auto ? w_tick : w_step_ev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
        end else if ((r_state == S_SHIFT) && w_auto) begin
            r_div <= w_tick ? '0 : r_div + AW'(1);
        end else begin
            r_div <= '0;
        end
    end

    // Outputs are registered alongside the state so they change only on the transition edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_idx     <= '0;
            r_x       <= 1'b0;
            r_x_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (w_load_ev) begin
            r_state   <= S_SHIFT;
            r_shreg   <= pattern;
            r_idx     <= '0;
            r_x       <= pattern[PAT_W-1];
            r_x_valid <= 1'b0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_SHIFT: begin
                    if (w_adv) begin
                        r_state   <= S_EMIT;
                        r_x_valid <= 1'b1;
                    end
                end
                S_EMIT: begin
                    r_x_valid <= 1'b0;
                    if (r_idx == IDX_LAST) begin
                        r_state <= S_DONE;
                        r_x     <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_SHIFT;
                        r_shreg <= r_shreg << 1;
                        r_idx   <= r_idx + IW'(1);
                        r_x     <= r_shreg[PAT_W-2];
                    end
                end
                default: ;
            endcase
        end
    end

    assign x       = r_x;
    assign x_valid = r_x_valid;
    assign bit_idx = r_idx;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_activ4_stim.sv
// Scoreboard bench for activ4_stim: a bit-list model queues expected pulses, a monitor pops them.
module tb_activ4_stim;

    localparam int PW = 8;
    localparam int DB = 4;
    localparam int AD = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          btn_load = 1'b0;
    logic          btn_step = 1'b0;
    logic          auto_run = 1'b0;
    logic [PW-1:0] pattern = '0;
    logic          x;
    logic          x_valid;
    logic [2:0]    bit_idx;
    logic          busy;
    logic          done;

    activ4_stim #(
        .PAT_W(PW),
        .DEBOUNCE_CYCLES(DB),
        .AUTO_DIV(AD)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .btn_load(btn_load),
        .btn_step(btn_step),
        .auto_run(auto_run),
        .pattern(pattern),
        .x(x),
        .x_valid(x_valid),
        .bit_idx(bit_idx),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic x;
        int   idx;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            n_chk = 0;
    int            n_pass = 0;
    int            cyc = 0;
    int            last_vld = -1;
    bit            chk_spacing = 1'b0;
    logic          prev_x = 1'b0;
    logic [PW-1:0] m_pat = '0;
    int            m_idx = 0;
    bit            m_active = 1'b0;
    logic [PW-1:0] p;

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
    endtask

    // Reference model: the loaded pattern is a list of bits consumed one per advance.
    task automatic m_load(input logic [PW-1:0] pat);
        m_pat    = pat;
        m_idx    = 0;
        m_active = 1'b1;
    endtask

    task automatic m_step();
        exp_t e;
        if (m_active) begin
            e.x   = m_pat[PW-1-m_idx];
            e.idx = m_idx;
            sb.push_back(e);
            m_idx++;
            if (m_idx == PW) m_active = 1'b0;
        end
    endtask

    task automatic press(input bit ld, input bit st, input int hold, input int gap);
        if (ld) m_load(pattern);
        else if (st && !auto_run) m_step();
        @(negedge clk);
        btn_load = ld;
        btn_step = st;
        repeat (hold) @(negedge clk);
        btn_load = 1'b0;
        btn_step = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic rstep();
        press(1'b0, 1'b1, $urandom_range(6, 10), $urandom_range(9, 13));
    endtask

    task automatic rload(input logic [PW-1:0] pat);
        pattern = pat;
        press(1'b1, 1'b0, $urandom_range(6, 10), $urandom_range(9, 13));
    endtask

    always @(negedge clk) begin
        cyc++;
        if (x_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_x_valid", int'(x_valid), 0);
            end else begin
                mon_e = sb.pop_front();
                chk("x_bit", int'(x), int'(mon_e.x));
                chk("bit_idx_at_pulse", int'(bit_idx), mon_e.idx);
            end
            chk("x_stable_before_pulse", int'(x), int'(prev_x));
            if (chk_spacing && last_vld >= 0) chk("auto_spacing", cyc - last_vld, AD + 1);
            last_vld = cyc;
        end
        prev_x = x;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_x", int'(x), 0);
        chk("reset_x_valid", int'(x_valid), 0);
        chk("reset_bit_idx", int'(bit_idx), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Steps in IDLE are ignored.
        rstep();
        rstep();
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);

        // Manual pattern.
        rload(8'b1011_0010);
        chk("load_busy", int'(busy), 1);
        chk("load_bit_idx", int'(bit_idx), 0);
        chk("load_x", int'(x), 1);
        for (int i = 0; i < PW; i++) rstep();
        chk("manual_drained", sb.size(), 0);
        chk("manual_done", int'(done), 1);
        chk("manual_busy", int'(busy), 0);
        chk("manual_x_after", int'(x), 0);

        // Steps in DONE are ignored; load in DONE restarts.
        rstep();
        chk("done_hold", int'(done), 1);
        p = 8'($urandom);
        rload(p);
        chk("reload_bit_idx", int'(bit_idx), 0);
        chk("reload_busy", int'(busy), 1);
        chk("reload_done", int'(done), 0);
        chk("reload_x", int'(x), int'(p[PW-1]));

        // Bounce rejection, then one clean press with exact latency.
        repeat (5) begin
            btn_step = 1'b1;
            repeat (3) @(negedge clk);
            btn_step = 1'b0;
            @(negedge clk);
        end
        repeat (8) @(negedge clk);
        chk("bounce_bit_idx", int'(bit_idx), 0);
        m_step();
        @(negedge clk);
        btn_step = 1'b1;
        repeat (DB + 2) @(posedge clk);
        #1 chk("latency_early", int'(x_valid), 0);
        @(posedge clk);
        #1 chk("latency_pulse", int'(x_valid), 1);
        repeat (3) @(negedge clk);
        btn_step = 1'b0;
        repeat (12) @(negedge clk);
        chk("bounce_drained", sb.size(), 0);
        chk("bounce_bit_idx_after", int'(bit_idx), 1);

        // Load and step land in the same cycle: load wins.
        rload(8'($urandom));
        for (int i = 0; i < 3; i++) rstep();
        chk("prio_bit_idx_before", int'(bit_idx), 3);
        pattern = 8'h0F;
        press(1'b1, 1'b1, 7, 12);
        chk("prio_bit_idx", int'(bit_idx), 0);
        chk("prio_x", int'(x), 0);
        chk("prio_busy", int'(busy), 1);
        rstep();
        chk("prio_drained", sb.size(), 0);

        // Auto-run with a step press in the middle that must be ignored.
        rload(8'hA5);
        for (int i = 0; i < PW; i++) m_step();
        last_vld    = -1;
        chk_spacing = 1'b1;
        @(negedge clk);
        auto_run = 1'b1;
        repeat (5) @(negedge clk);
        press(1'b0, 1'b1, 6, 1);
        for (int i = 0; i < 200 && !done; i++) @(negedge clk);
        chk("auto_done", int'(done), 1);
        chk("auto_drained", sb.size(), 0);
        repeat (2) @(negedge clk);
        chk_spacing = 1'b0;
        auto_run    = 1'b0;
        repeat (12) @(negedge clk);

        // Reset in the middle of a pattern.
        rload(8'($urandom));
        for (int i = 0; i < 5; i++) rstep();
        chk("rst_bit_idx_before", int'(bit_idx), 5);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_x", int'(x), 0);
        chk("midrst_x_valid", int'(x_valid), 0);
        chk("midrst_bit_idx", int'(bit_idx), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        m_active = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        rstep();
        rstep();
        chk("postrst_busy", int'(busy), 0);
        chk("postrst_done", int'(done), 0);

        chk("final_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
